// File: rtl/md_pkg.sv
// Shared constants and types for the multiply/divide sequencer.
package md_pkg;

  // Opcode and function codes for the SPECIAL-group multiply/divide instructions
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] FN_MFHI    = 6'h10;
  localparam logic [5:0] FN_MTHI    = 6'h11;
  localparam logic [5:0] FN_MFLO    = 6'h12;
  localparam logic [5:0] FN_MTLO    = 6'h13;
  localparam logic [5:0] FN_MULT    = 6'h18;
  localparam logic [5:0] FN_MULTU   = 6'h19;
  localparam logic [5:0] FN_DIV     = 6'h1a;
  localparam logic [5:0] FN_DIVU    = 6'h1b;

  // Default unit latencies and shadow counter width
  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;
  localparam int CNT_W_DEF   = 4;

  typedef enum logic [1:0] {
    CLS_NONE = 2'd0,
    CLS_MDOP = 2'd1,
    CLS_MDRD = 2'd2,
    CLS_MDWR = 2'd3
  } md_class_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_BUSY = 2'd2
  } md_state_t;

endpackage

// File: rtl/md_sched_if.sv
// Pipeline/unit-facing signals of the multiply/divide sequencer.
// With MD_SCHED_PERF_EN defined, the perf_stall/perf_ops counters are added.
interface md_sched_if;
  logic [31:0] instr_d;
  logic [31:0] instr_e;
  logic        valid_e;
  logic        flush_e;
  logic        md_busy;
  logic        md_start;
  logic        stall_d;
  logic [1:0]  err;
`ifdef MD_SCHED_PERF_EN
  logic [31:0] perf_stall;
  logic [15:0] perf_ops;
`endif

  // Pipeline / unit side
  modport master (
`ifdef MD_SCHED_PERF_EN
    input  perf_stall, perf_ops,
`endif
    output instr_d, instr_e, valid_e, flush_e, md_busy,
    input  md_start, stall_d, err
  );

  // Sequencer side
  modport slave (
`ifdef MD_SCHED_PERF_EN
    output perf_stall, perf_ops,
`endif
    input  instr_d, instr_e, valid_e, flush_e, md_busy,
    output md_start, stall_d, err
  );
endinterface

// File: rtl/md_decode.sv
// Combinational classifier: instruction word -> HI/LO access class and divide flag.
module md_decode
  import md_pkg::*;
(
  input  logic [31:0] instr,
  output md_class_t   cls,
  output logic        is_div
);

  logic [5:0] op;
  logic [5:0] fn;
  logic       unused_bits;

  assign op          = instr[31:26];
  assign fn          = instr[5:0];
  assign unused_bits = ^instr[25:6];

  // Classify on opcode/function fields
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    cls    = CLS_NONE;
    is_div = 1'b0;
    if (op == OP_SPECIAL) begin
      case (fn)
        FN_MULT, FN_MULTU: cls = CLS_MDOP;
        FN_DIV, FN_DIVU: begin
          cls    = CLS_MDOP;
          is_div = 1'b1;
        end
        FN_MFHI, FN_MFLO: cls = CLS_MDRD;
        FN_MTHI, FN_MTLO: cls = CLS_MDWR;
        default:          cls = CLS_NONE;
      endcase
    end
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer: issues start, bridges start->busy, stalls D on HI/LO
// hazards and shadows the unit latency to flag protocol errors.
// Optional feature: MD_SCHED_PERF_EN adds stall-cycle and issue counters.
module md_sched
  import md_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF,
  parameter int CNT_W   = CNT_W_DEF
) (
  input  logic       clk,
  input  logic       reset,
  md_sched_if.slave  bus
);

  md_class_t        class_d, class_e;
  logic             is_div_e;
  logic             unused_is_div_d;
  md_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       err_q, err_d;
  logic             issue_req;
  logic             start;
  logic             stall;

  md_decode u_dec_d (.instr(bus.instr_d), .cls(class_d), .is_div(unused_is_div_d));
  md_decode u_dec_e (.instr(bus.instr_e), .cls(class_e), .is_div(is_div_e));

  // A live MDOP in E wants to issue regardless of FSM state
  assign issue_req = bus.valid_e & ~bus.flush_e & (class_e == CLS_MDOP);

  // State, shadow counter and sticky error registers
  always_ff @(posedge clk or negedge reset) begin
    // NOTE: async reset clears all state; the unit shares this reset so nothing resumes.
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      err_q   <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next state, latency tracking and error detection
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    if (issue_req && state_q != ST_IDLE) err_d[1] = 1'b1;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_PEND;
          cnt_d   = is_div_e ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);
        end
      end
      ST_PEND: begin
        if (bus.md_busy) begin
          state_d = ST_BUSY;
          cnt_d   = cnt_q - CNT_W'(1);
        end else begin
          err_d[0] = 1'b1;
          state_d  = ST_IDLE;
          cnt_d    = '0;
        end
      end
      ST_BUSY: begin
        if (!bus.md_busy) begin
          if (cnt_q != '0) err_d[0] = 1'b1;
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          // Unit overran its expected latency: hold at 0 until busy falls
          err_d[0] = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Start pulse and decode stall, both forced low while reset is asserted
  always_comb begin
    start = reset & issue_req & (state_q == ST_IDLE);
    stall = reset & (class_d != CLS_NONE) & ((state_q != ST_IDLE) | start);
  end

  assign bus.md_start = start;
  assign bus.stall_d  = stall;
  assign bus.err      = err_q;

`ifdef MD_SCHED_PERF_EN
  logic [31:0] perf_stall_q;
  logic [15:0] perf_ops_q;

  // Free-running wrap-around counters of stall cycles and issued operations
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      perf_stall_q <= '0;
      perf_ops_q   <= '0;
    end else begin
      if (stall) perf_stall_q <= perf_stall_q + 32'd1;
      if (start) perf_ops_q   <= perf_ops_q + 16'd1;
    end
  end

  assign bus.perf_stall = perf_stall_q;
  assign bus.perf_ops   = perf_ops_q;
`endif

endmodule

// File: tb/tb_md_sched.sv
// Directed self-checking bench for md_sched.
module tb_md_sched;

  localparam logic [31:0] I_NOP  = 32'h0000_0000;
  localparam logic [31:0] I_MULT = 32'h0085_0018;
  localparam logic [31:0] I_DIV  = 32'h0085_001a;
  localparam logic [31:0] I_MFHI = 32'h0000_0010;
  localparam logic [31:0] I_MFLO = 32'h0000_1012;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  md_sched_if bus ();

  md_sched dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Advance to the next falling edge, apply one cycle of inputs, let comb logic settle
  task automatic step(input logic [31:0] d, input logic [31:0] e, input logic v,
                      input logic f, input logic b);
    @(negedge clk);
    bus.instr_d = d;
    bus.instr_e = e;
    bus.valid_e = v;
    bus.flush_e = f;
    bus.md_busy = b;
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    step(I_MFHI, I_MULT, 1'b1, 1'b0, 1'b0);
    check("rst_start", {31'd0, bus.md_start}, 32'd0);
    check("rst_stall", {31'd0, bus.stall_d}, 32'd0);
    check("rst_err", {30'd0, bus.err}, 32'd0);
    step(I_NOP, I_NOP, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    reset       = 1'b0;
    bus.instr_d = I_NOP;
    bus.instr_e = I_NOP;
    bus.valid_e = 1'b0;
    bus.flush_e = 1'b0;
    bus.md_busy = 1'b0;

    // 1: mult issue with 5-cycle busy, mfhi in D to observe FSM via stall
    do_reset();
    step(I_MFHI, I_MULT, 1'b1, 1'b0, 1'b0);
    check("t1_start", {31'd0, bus.md_start}, 32'd1);
    check("t1_stall_issue", {31'd0, bus.stall_d}, 32'd1);
    step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b1);
    check("t1_start_pend", {31'd0, bus.md_start}, 32'd0);
    check("t1_stall_pend", {31'd0, bus.stall_d}, 32'd1);
    for (int i = 2; i <= 5; i++) begin
      step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b1);
      check("t1_stall_busy", {31'd0, bus.stall_d}, 32'd1);
    end
    step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b0);
    check("t1_stall_fall", {31'd0, bus.stall_d}, 32'd1);
    step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b0);
    check("t1_stall_idle", {31'd0, bus.stall_d}, 32'd0);
    check("t1_err", {30'd0, bus.err}, 32'd0);

    // 2: div with mflo in D; stall from issue through busy-low cycle (12 cycles)
    step(I_MFLO, I_DIV, 1'b1, 1'b0, 1'b0);
    check("t2_start", {31'd0, bus.md_start}, 32'd1);
    check("t2_stall_issue", {31'd0, bus.stall_d}, 32'd1);
    for (int i = 1; i <= 10; i++) begin
      step(I_MFLO, I_NOP, 1'b0, 1'b0, 1'b1);
      check("t2_stall_busy", {31'd0, bus.stall_d}, 32'd1);
    end
    step(I_MFLO, I_NOP, 1'b0, 1'b0, 1'b0);
    check("t2_stall_fall", {31'd0, bus.stall_d}, 32'd1);
    step(I_MFLO, I_NOP, 1'b0, 1'b0, 1'b0);
    check("t2_stall_rel", {31'd0, bus.stall_d}, 32'd0);
    check("t2_err", {30'd0, bus.err}, 32'd0);

    // 3: flushed mult does not issue, FSM stays IDLE
    step(I_MFHI, I_MULT, 1'b1, 1'b1, 1'b0);
    check("t3_start", {31'd0, bus.md_start}, 32'd0);
    check("t3_stall", {31'd0, bus.stall_d}, 32'd0);
    step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b0);
    check("t3_stall_next", {31'd0, bus.stall_d}, 32'd0);

    // 4: mult with busy only 3 cycles -> latency error, sticky
    step(I_MFHI, I_MULT, 1'b1, 1'b0, 1'b0);
    check("t4_start", {31'd0, bus.md_start}, 32'd1);
    for (int i = 1; i <= 3; i++) step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b1);
    step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b0);
    check("t4_err_before", {30'd0, bus.err}, 32'd0);
    check("t4_stall_fall", {31'd0, bus.stall_d}, 32'd1);
    step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b0);
    check("t4_err", {30'd0, bus.err}, 32'd1);
    check("t4_idle", {31'd0, bus.stall_d}, 32'd0);
    step(I_NOP, I_NOP, 1'b0, 1'b0, 1'b0);
    step(I_NOP, I_NOP, 1'b0, 1'b0, 1'b0);
    check("t4_sticky", {30'd0, bus.err}, 32'd1);

    // 5a: busy never rises -> error after PEND, back to IDLE
    do_reset();
    check("t5_err_clr", {30'd0, bus.err}, 32'd0);
    step(I_MFHI, I_MULT, 1'b1, 1'b0, 1'b0);
    check("t5_start", {31'd0, bus.md_start}, 32'd1);
    step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b0);
    check("t5_stall_pend", {31'd0, bus.stall_d}, 32'd1);
    step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b0);
    check("t5_err_pend", {30'd0, bus.err}, 32'd1);
    check("t5_idle", {31'd0, bus.stall_d}, 32'd0);

    // 5b: reset mid-BUSY of a div forces outputs low and clears err at once
    step(I_MFHI, I_DIV, 1'b1, 1'b0, 1'b0);
    check("t5_div_start", {31'd0, bus.md_start}, 32'd0 + 32'd1);
    for (int i = 1; i <= 3; i++) step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b1);
    check("t5_busy_stall", {31'd0, bus.stall_d}, 32'd1);
    bus.instr_e = I_DIV;
    bus.valid_e = 1'b1;
    reset = 1'b0;
    #1;
    check("t5_async_start", {31'd0, bus.md_start}, 32'd0);
    check("t5_async_stall", {31'd0, bus.stall_d}, 32'd0);
    check("t5_async_err", {30'd0, bus.err}, 32'd0);
    step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b0);
    reset = 1'b1;
    #1;
    check("t5_post_idle", {31'd0, bus.stall_d}, 32'd0);

    // Illegal issue while BUSY: start suppressed, err[1] set
    step(I_MFHI, I_MULT, 1'b1, 1'b0, 1'b0);
    check("ill_first", {31'd0, bus.md_start}, 32'd1);
    step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b1);
    step(I_MFHI, I_MULT, 1'b1, 1'b0, 1'b1);
    check("ill_start", {31'd0, bus.md_start}, 32'd0);
    for (int i = 3; i <= 5; i++) step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b1);
    step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b0);
    step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b0);
    check("ill_err", {30'd0, bus.err}, 32'd2);
    check("ill_idle", {31'd0, bus.stall_d}, 32'd0);

`ifdef MD_SCHED_PERF_EN
    // 6: two back-to-back mults with mfhi in D -> 14 stall cycles, 2 ops
    do_reset();
    check("t6_ops_rst", {16'd0, bus.perf_ops}, 32'd0);
    check("t6_stall_rst", bus.perf_stall, 32'd0);
    for (int k = 0; k < 2; k++) begin
      step(I_MFHI, I_MULT, 1'b1, 1'b0, 1'b0);
      check("t6_start", {31'd0, bus.md_start}, 32'd1);
      for (int i = 1; i <= 5; i++) step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b1);
      step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b0);
    end
    step(I_MFHI, I_NOP, 1'b0, 1'b0, 1'b0);
    check("t6_stall_off", {31'd0, bus.stall_d}, 32'd0);
    check("t6_ops", {16'd0, bus.perf_ops}, 32'd2);
    check("t6_stall_cnt", bus.perf_stall, 32'd14);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
